// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retire-trace sink: record layout, sender states and
// the mapping from record to the three streamed words.
package mips_trace_pkg;

    localparam int STAMP_W = 15;
    localparam int PC_W    = 10;

    localparam logic [1:0] WIDX_HDR   = 2'd0;
    localparam logic [1:0] WIDX_INSTR = 2'd1;
    localparam logic [1:0] WIDX_WDATA = 2'd2;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [4:0]         dest;
        logic               rw;
        logic               mw;
        logic [PC_W-1:0]    pc;
        logic [31:0]        instr;
        logic [31:0]        wdata;
    } trace_rec_t;

    typedef enum logic [1:0] {IDLE, W0, W1, W2} trace_state_e;

    function automatic logic [31:0] rec_word(input trace_rec_t r, input logic [1:0] idx);
        case (idx)
            WIDX_HDR:   return {r.stamp, r.dest, r.rw, r.mw, r.pc};
            WIDX_INSTR: return r.instr;
            WIDX_WDATA: return r.wdata;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with first-word-fall-through head; the caller guarantees
// no push when full unless a pop happens in the same cycle.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     push,
    input  trace_rec_t               push_rec,
    input  logic                     pop,
    output trace_rec_t               head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge aclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips_trace_capture.sv
// Retire-trace sink: captures core write events into a FIFO and streams each record
// as three words over valid/ready. Define TRACE_ALL_EN to capture every non-stalled instruction.
module mips_trace_capture
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [9:0]                 PC,
    input  logic [31:0]                Instruction_out,
    input  logic [31:0]                write_data_out,
    input  logic [4:0]                 dest_out,
    input  logic                       RegWrite_out,
    input  logic                       MemWrite_out,
    input  logic                       stall_out,
    output logic                       tr_valid,
    output logic [31:0]                tr_data,
    output logic                       tr_last,
    input  logic                       tr_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [OVF_W-1:0]           ovf_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

    trace_state_e         state;
    trace_state_e         state_nxt;
    logic [STAMP_W-1:0]   stamp;
    logic                 cap_evt;
    logic                 push;
    logic                 pop;
    trace_rec_t           cap_rec;
    trace_rec_t           head;

`ifdef TRACE_ALL_EN
    assign cap_evt = enable & ~stall_out;
`else
    assign cap_evt = enable & ~stall_out & (RegWrite_out | MemWrite_out);
`endif

    // The head record leaves the FIFO only once its last word is accepted.
    assign pop  = (state == W2) & tr_ready;
    assign push = cap_evt & ((fifo_level < FULL_LVL) | pop);

    assign cap_rec = '{stamp: stamp, dest: dest_out, rw: RegWrite_out, mw: MemWrite_out,
                       pc: PC, instr: Instruction_out, wdata: write_data_out};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .aclk     (aclk),
        .reset    (reset),
        .push     (push),
        .push_rec (cap_rec),
        .pop      (pop),
        .head     (head),
        .level    (fifo_level)
    );

    always_ff @(posedge aclk) begin
        if (!reset) begin
            stamp   <= '0;
            ovf_cnt <= '0;
            state   <= IDLE;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            if (cap_evt && !push) ovf_cnt <= sat_inc(ovf_cnt);
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tr_valid  = 1'b0;
        tr_last   = 1'b0;
        tr_data   = '0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) state_nxt = W0;
            end
            W0: begin
                tr_valid = 1'b1;
                tr_data  = rec_word(head, WIDX_HDR);
                if (tr_ready) state_nxt = W1;
            end
            W1: begin
                tr_valid = 1'b1;
                tr_data  = rec_word(head, WIDX_INSTR);
                if (tr_ready) state_nxt = W2;
            end
            W2: begin
                tr_valid = 1'b1;
                tr_last  = 1'b1;
                tr_data  = rec_word(head, WIDX_WDATA);
                // A record pushed alongside the pop keeps the stream going without a bubble.
                if (tr_ready) state_nxt = (fifo_level > LVL_ONE || push) ? W0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
